// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: blank/dash patterns and digit table.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Segment order is {a,b,c,d,e,f,g} with a in the MSB; a 0 bit lights the segment.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [3:0] CODE_DASH = 4'd10;

  // Patterns for decimal codes 0..9, indexed by code value.
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100   // 9
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment pattern decoder (0-9 digits, 10 dash, 11-15 blank).
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: i_code = 4-bit digit code, o_seg = active-low {a..g} pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (i_code == CODE_DASH) begin
      o_seg = SEG_DASH;
    end else begin
      for (int k = 0; k < 10; k++) begin
        if (i_code == 4'(k)) o_seg = SEG_TABLE[k];
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scan with guard blank, blink, leading-zero suppression, enable.
// Latency: 1 clk from DigitNums to Displayer while that digit is active; all outputs registered.
// Backpressure: none; Enable=0 freezes scan state and darkens the display.
// Ports: clk/rst_n (async active-low); Enable; DigitNums (4 bits per digit, digit 0 rightmost);
//        BlinkMask; ZeroSuppress; Displayer (active-low segments); DigitSel (one-hot); FrameTick.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int CLK_DIV       = 50000,
  parameter int BLINK_DIV     = 64,
  parameter bit DIGIT_ACT_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] DigitNums,
  input  logic [NUM_DIGITS-1:0]   BlinkMask,
  input  logic                    ZeroSuppress,
  output logic [6:0]              Displayer,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output logic                    FrameTick
);

  localparam int PW = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  // Idle level of every select line; XOR with a one-hot gives the active pattern in either polarity.
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{DIGIT_ACT_LOW}};

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_blink_cnt;
  logic                  r_blink_phase;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_sel;
  logic                  r_tick;

  logic [3:0]            w_code;
  logic [6:0]            w_dec;
  logic                  w_blink_on;
  logic                  w_lead_zero;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_guard;
  logic                  w_wrap;

  // Walk from the most significant digit down so w_zero_run tells whether the
  // current position and everything above it are all code 0.
  always_comb begin
    w_code      = 4'd0;
    w_blink_on  = 1'b0;
    w_lead_zero = 1'b0;
    w_onehot    = '0;
    w_zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (DigitNums[4*k +: 4] == 4'd0);
      if (r_idx == IW'(k)) begin
        w_code      = DigitNums[4*k +: 4];
        w_blink_on  = BlinkMask[k] && r_blink_phase;
        w_lead_zero = ZeroSuppress && (k != 0) && w_zero_run;
        w_onehot[k] = 1'b1;
      end
    end
  end

  assign w_guard = (r_presc == PRESC_LAST);
  assign w_wrap  = w_guard && (r_idx == IDX_LAST);

  seg7_decode u_decode (
    .i_code (w_code),
    .o_seg  (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_seg         <= SEG_BLANK;
      r_sel         <= SEL_IDLE;
      r_tick        <= 1'b0;
    end else if (!Enable) begin
      r_seg  <= SEG_BLANK;
      r_sel  <= SEL_IDLE;
      r_tick <= 1'b0;
    end else if (w_guard) begin
      // Anti-ghost cycle: all digits off while the index moves on.
      r_presc <= '0;
      r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      r_seg   <= SEG_BLANK;
      r_sel   <= SEL_IDLE;
      r_tick  <= w_wrap;
      if (w_wrap) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end else begin
      r_presc <= r_presc + 1'b1;
      r_sel   <= w_onehot ^ SEL_IDLE;
      r_seg   <= (w_blink_on || w_lead_zero) ? SEG_BLANK : w_dec;
      r_tick  <= 1'b0;
    end
  end

  assign Displayer = r_seg;
  assign DigitSel  = r_sel;
  assign FrameTick = r_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios plus random traffic checked against an arithmetic model.
// Latency: model predicts the registered outputs one edge after the sampled inputs.
// Backpressure: n/a.
module tb_seg_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Enable;
  logic [4*ND-1:0] DigitNums;
  logic [ND-1:0] BlinkMask;
  logic          ZeroSuppress;
  logic [6:0]    Displayer;
  logic [ND-1:0] DigitSel;
  logic          FrameTick;

  int errors = 0;
  int checks = 0;
  int n_en   = 0;   // enabled edges since the last reset

  seg_scan_driver #(
    .NUM_DIGITS    (ND),
    .CLK_DIV       (CD),
    .BLINK_DIV     (BD),
    .DIGIT_ACT_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Enable       (Enable),
    .DigitNums    (DigitNums),
    .BlinkMask    (BlinkMask),
    .ZeroSuppress (ZeroSuppress),
    .Displayer    (Displayer),
    .DigitSel     (DigitSel),
    .FrameTick    (FrameTick)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input int c);
    case (c)
      0: return 7'b0000001;  1: return 7'b1001111;
      2: return 7'b0010010;  3: return 7'b0000110;
      4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;
      8: return 7'b0000000;  9: return 7'b0000100;
      10: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at t=%0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One clock edge: the model derives slot, digit, frame and blink phase from the
  // number of enabled edges since reset, then the outputs are compared 1 time unit later.
  task automatic step();
    logic [6:0]    e_seg;
    logic [ND-1:0] e_sel;
    logic          e_tick;
    int pos, idx, frame, phase, hi, code;
    @(posedge clk);
    e_seg = 7'h7F; e_sel = '1; e_tick = 1'b0;
    if (Enable) begin
      n_en++;
      pos   = (n_en - 1) % CD;
      idx   = ((n_en - 1) / CD) % ND;
      frame = (n_en - 1) / (CD * ND);
      phase = (frame / BD) % 2;
      if (pos == CD - 1) begin
        e_tick = (idx == ND - 1);
      end else begin
        e_sel = ~(ND'(1) << idx);
        code  = int'(DigitNums[4*idx +: 4]);
        hi = -1;
        for (int k = 0; k < ND; k++) if (DigitNums[4*k +: 4] != 4'd0) hi = k;
        e_seg = ref_seg(code);
        if ((phase == 1 && BlinkMask[idx]) || (ZeroSuppress && idx != 0 && idx > hi))
          e_seg = 7'h7F;
      end
    end
    #1;
    chk("Displayer", 32'(Displayer), 32'(e_seg));
    chk("DigitSel",  32'(DigitSel),  32'(e_sel));
    chk("FrameTick", 32'(FrameTick), 32'(e_tick));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"},  32'(Displayer), 32'h7F);
    chk({tag, "_sel"},  32'(DigitSel),  32'hF);
    chk({tag, "_tick"}, 32'(FrameTick), 32'h0);
  endtask

  // Called just after a posedge: asserts reset mid-cycle, checks without an edge, then releases.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #2 check_reset_outputs("async_rst");
    @(posedge clk);
    #2 check_reset_outputs("held_rst");
    rst_n = 1'b1;
    n_en  = 0;
  endtask

  initial begin
    rst_n = 1'b0; Enable = 1'b1; DigitNums = 16'h4321; BlinkMask = '0; ZeroSuppress = 1'b0;
    #12 check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Scan timing, with a few hard-coded expectations alongside the model.
    for (int e = 1; e <= 40; e++) begin
      step();
      if (e == 1) begin
        chk("edge1_sel", 32'(DigitSel), 32'hE);
        chk("edge1_seg", 32'(Displayer), 32'(7'b1001111));
      end
      if (e == 4) chk("edge4_sel", 32'(DigitSel), 32'hF);
      if (e == 5) chk("edge5_seg", 32'(Displayer), 32'(7'b0010010));
      if (e == 16 || e == 32) chk("frame_tick", 32'(FrameTick), 32'h1);
    end

    // Code map on digit 0, one full frame per code.
    for (int c = 0; c < 16; c++) begin
      DigitNums = {12'h987, 4'(c)};
      run(CD * ND);
    end

    // Leading-zero suppression.
    ZeroSuppress = 1'b1;
    DigitNums = 16'h0070; run(CD * ND);
    DigitNums = 16'h0000; run(CD * ND);
    DigitNums = 16'hA000; run(CD * ND);
    ZeroSuppress = 1'b0;

    // Blink from a fresh reset so frame numbering starts at 0.
    async_reset();
    BlinkMask = 4'b0011; DigitNums = 16'h1234;
    for (int e = 1; e <= 5 * CD * ND; e++) begin
      step();
      if (e == 2)           chk("blink_f0_d0", 32'(Displayer), 32'(7'b1001100));
      if (e == 2*CD*ND + 2) chk("blink_f2_d0", 32'(Displayer), 32'h7F);
      if (e == 2*CD*ND + 3*CD + 2) chk("blink_f2_d3", 32'(Displayer), 32'(7'b1001111));
      if (e == 4*CD*ND + 2) chk("blink_f4_d0", 32'(Displayer), 32'(7'b1001100));
    end
    BlinkMask = '0;

    // Enable drop mid-slot on digit 2, hold for 10 cycles, resume.
    async_reset();
    DigitNums = 16'h5678;
    run(2 * CD + 1);
    Enable = 1'b0; run(10);
    Enable = 1'b1; run(2 * CD);

    // Live update of digit 1 while it is being shown.
    async_reset();
    DigitNums = 16'h0050;
    run(CD + 1);
    DigitNums = 16'h0080;
    step();
    chk("live_update", 32'(Displayer), 32'(7'b0000000));
    run(3 * CD * ND);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < ND; k++)
          DigitNums[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 31) == 0) BlinkMask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) ZeroSuppress = 1'($urandom);
      Enable = ($urandom_range(0, 9) != 0);
      step();
      if (i == 700) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
